// File: rtl/fetch_control.sv
// fetch_control -- fetch-side pipeline control for the pipelined LEGv8 core.
//
// Owns the PC register and the pipeline fill counter. Each cycle it decides
// whether the PC advances, holds or redirects to a resolved branch target.
// It also decides whether IF/ID loads, loads a bubble, or holds, and whether
// ID/EX receives a bubble.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   stall          stall request from hazard detection
//   branch_taken   one-cycle pulse: branch in MEM/WB resolved taken
//   branch_target  redirect address, valid while branch_taken=1
//   stage          pipeline fill counter (saturates at 4), to hazard detection
//   pc             current fetch address
//   ifid_write     IF/ID load enable
//   ifid_flush     IF/ID loads a bubble instead of the fetched word
//   idex_bubble    ID/EX loads a bubble
//   deadlock       sticky stall watchdog flag
//
// Optional feature: define HAZARD_WATCHDOG_EN to build the stall-run
// watchdog. Without it, deadlock is tied to 0.

`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef COUNTERSIZE
`define COUNTERSIZE 3
`endif

module fetch_control #(
  parameter logic [`WORDSIZE-1:0] RESETPC     = '0,
  parameter int                   STALL_LIMIT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [`WORDSIZE-1:0]    branch_target,
  output logic [`COUNTERSIZE-1:0] stage,
  output logic [`WORDSIZE-1:0]    pc,
  output logic                    ifid_write,
  output logic                    ifid_flush,
  output logic                    idex_bubble,
  output logic                    deadlock
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  localparam logic [`COUNTERSIZE-1:0] STAGE_FULL = `COUNTERSIZE'(4);

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [`COUNTERSIZE-1:0] stage_next;
  logic                    hold_req;

  // A redirect always overrides a stall request.
  assign hold_req = stall && !branch_taken;

  assign ifid_write  = !stall || branch_taken;
  assign ifid_flush  = branch_taken;
  assign idex_bubble = hold_req;

  assign stage_next = (stage == STAGE_FULL) ? stage : stage + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (hold_req)                      state_next = STALL;
        else if (stage_next == STAGE_FULL) state_next = RUN;
      end
      RUN: begin
        if (hold_req) state_next = STALL;
      end
      STALL: begin
        if (!hold_req) state_next = RUN;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      stage <= '0;
      pc    <= RESETPC;
    end else begin
      state <= state_next;
      stage <= stage_next;
      if (branch_taken)
        pc <= {branch_target[`WORDSIZE-1:2], 2'b00};
      else if (!stall)
        pc <= pc + `WORDSIZE'(4);
    end
  end

`ifdef HAZARD_WATCHDOG_EN
  localparam int                 RUN_W = $clog2(STALL_LIMIT + 1) + 1;
  localparam logic [RUN_W-1:0]   LIMIT = RUN_W'(STALL_LIMIT);

  logic [RUN_W-1:0] stall_run;
  logic [RUN_W-1:0] stall_run_inc;

  // Saturate so a very long stall cannot wrap the count.
  assign stall_run_inc = (stall_run >= LIMIT) ? stall_run : stall_run + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_run <= '0;
      deadlock  <= 1'b0;
    end else if (state_next == STALL) begin
      stall_run <= stall_run_inc;
      if (stall_run_inc >= LIMIT) deadlock <= 1'b1;
    end else begin
      stall_run <= '0;
    end
  end
`else
  logic unused_stall_limit;
  assign unused_stall_limit = ^STALL_LIMIT;
  assign deadlock           = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef COUNTERSIZE
`define COUNTERSIZE 3
`endif

module tb_fetch_control;

  localparam logic [63:0] RPC   = 64'h1000;
  localparam int          LIMIT = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    stall;
  logic                    branch_taken;
  logic [`WORDSIZE-1:0]    branch_target;
  logic [`COUNTERSIZE-1:0] stage;
  logic [`WORDSIZE-1:0]    pc;
  logic                    ifid_write, ifid_flush, idex_bubble, deadlock;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [63:0] m_pc;
  int          m_stage;
  int          m_run;
  logic        m_dl;

  fetch_control #(.RESETPC(RPC), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .stage(stage), .pc(pc),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  task automatic model_clock();
    if (reset) begin
      m_pc = RPC; m_stage = 0; m_run = 0; m_dl = 1'b0;
    end else begin
      if (m_stage < 4) m_stage = m_stage + 1;
      if (branch_taken)  m_pc = branch_target & ~64'd3;
      else if (!stall)   m_pc = m_pc + 64'd4;
`ifdef HAZARD_WATCHDOG_EN
      if (stall && !branch_taken) begin
        m_run = m_run + 1;
        if (m_run >= LIMIT) m_dl = 1'b1;
      end else m_run = 0;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [63:0] t);
    reset = r; stall = s; branch_taken = b; branch_target = t;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    total++; if (ifid_write !== 1'b1) $display("FAIL reset_ifid_write: got %b want 1", ifid_write); else passed++;
    total++; if (ifid_flush !== 1'b0) $display("FAIL reset_ifid_flush: got %b want 0", ifid_flush); else passed++;
    total++; if (idex_bubble !== 1'b0) $display("FAIL reset_idex_bubble: got %b want 0", idex_bubble); else passed++;
    tick(); tick();
    total++; if (pc !== RPC) $display("FAIL reset_pc: got %h want %h", pc, RPC); else passed++;
    total++; if (stage !== 3'd0) $display("FAIL reset_stage: got %0d want 0", stage); else passed++;
    total++; if (deadlock !== 1'b0) $display("FAIL reset_deadlock: got %b want 0", deadlock); else passed++;
  endtask

  task automatic test_fill();
    int exp_stage [6] = '{1, 2, 3, 4, 4, 4};
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (stage !== 3'(exp_stage[i])) $display("FAIL fill_stage[%0d]: got %0d want %0d", i, stage, exp_stage[i]); else passed++;
      total++; if (pc !== RPC + 64'(4 * (i + 1))) $display("FAIL fill_pc[%0d]: got %h want %h", i, pc, RPC + 64'(4 * (i + 1))); else passed++;
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b1, 64'h40);
    tick();
    total++; if (pc !== 64'h40) $display("FAIL stall_setup_pc: got %h want 40", pc); else passed++;
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 2; i++) begin
      total++; if (ifid_write !== 1'b0) $display("FAIL stall_ifid_write[%0d]: got %b want 0", i, ifid_write); else passed++;
      total++; if (idex_bubble !== 1'b1) $display("FAIL stall_idex_bubble[%0d]: got %b want 1", i, idex_bubble); else passed++;
      tick();
      total++; if (pc !== 64'h40) $display("FAIL stall_pc[%0d]: got %h want 40", i, pc); else passed++;
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++; if (pc !== 64'h44) $display("FAIL stall_resume_pc: got %h want 44", pc); else passed++;
  endtask

  task automatic test_branch();
    tick(); // 0x44 -> 0x48
    drive(1'b0, 1'b0, 1'b1, 64'h200);
    total++; if (ifid_flush !== 1'b1) $display("FAIL branch_flush: got %b want 1", ifid_flush); else passed++;
    total++; if (pc !== 64'h48) $display("FAIL branch_pc_before: got %h want 48", pc); else passed++;
    tick();
    total++; if (pc !== 64'h200) $display("FAIL branch_pc_target: got %h want 200", pc); else passed++;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++; if (pc !== 64'h204) $display("FAIL branch_pc_next: got %h want 204", pc); else passed++;
  endtask

  task automatic test_stall_branch();
    drive(1'b0, 1'b1, 1'b1, 64'h103);
    total++; if (idex_bubble !== 1'b0) $display("FAIL sb_idex_bubble: got %b want 0", idex_bubble); else passed++;
    total++; if (ifid_flush !== 1'b1) $display("FAIL sb_ifid_flush: got %b want 1", ifid_flush); else passed++;
    total++; if (ifid_write !== 1'b1) $display("FAIL sb_ifid_write: got %b want 1", ifid_write); else passed++;
    tick();
    total++; if (pc !== 64'h100) $display("FAIL sb_pc: got %h want 100", pc); else passed++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    total++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_target: got %h want fffffffffffffffc", pc); else passed++;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++; if (pc !== 64'h0) $display("FAIL wrap_pc: got %h want 0", pc); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 1'b0, 1'b1, 64'h80);
    tick();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    total++; if (pc !== 64'h80) $display("FAIL rms_pc_hold: got %h want 80", pc); else passed++;
    drive(1'b1, 1'b1, 1'b1, 64'h300);
    tick();
    total++; if (pc !== RPC) $display("FAIL rms_pc: got %h want %h", pc, RPC); else passed++;
    total++; if (stage !== 3'd0) $display("FAIL rms_stage: got %0d want 0", stage); else passed++;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    total++; if (pc !== RPC + 64'd4) $display("FAIL rms_restart_pc: got %h want %h", pc, RPC + 64'd4); else passed++;
    total++; if (stage !== 3'd1) $display("FAIL rms_restart_stage: got %0d want 1", stage); else passed++;
  endtask

  task automatic test_watchdog();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (deadlock !== m_dl) $display("FAIL wd_stall[%0d]: got %b want %b", i, deadlock, m_dl); else passed++;
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick(); tick();
    total++; if (deadlock !== m_dl) $display("FAIL wd_sticky: got %b want %b", deadlock, m_dl); else passed++;
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    total++; if (deadlock !== 1'b0) $display("FAIL wd_reset_clear: got %b want 0", deadlock); else passed++;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) == 0), {$urandom, $urandom});
      total++; if (ifid_write !== (!stall || branch_taken)) $display("FAIL rnd_ifid_write[%0d]: got %b", i, ifid_write); else passed++;
      total++; if (ifid_flush !== branch_taken) $display("FAIL rnd_ifid_flush[%0d]: got %b want %b", i, ifid_flush, branch_taken); else passed++;
      total++; if (idex_bubble !== (stall && !branch_taken)) $display("FAIL rnd_idex_bubble[%0d]: got %b", i, idex_bubble); else passed++;
      tick();
      total++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); else passed++;
      total++; if (stage !== 3'(m_stage)) $display("FAIL rnd_stage[%0d]: got %0d want %0d", i, stage, m_stage); else passed++;
      total++; if (deadlock !== m_dl) $display("FAIL rnd_deadlock[%0d]: got %b want %b", i, deadlock, m_dl); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_pc = RPC; m_stage = 0; m_run = 0; m_dl = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_stall();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_reset_mid_stall();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
